// File: rtl/sorted_list_streamer_pkg.sv
// Types and helpers shared between the list sorter and the sorted-list streamer.
package sorted_list_streamer_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned Length    = 8;

  typedef logic [DataWidth-1:0] elem_t;
  typedef elem_t [Length-1:0]   vec_t;

  typedef enum logic {StIdle, StStream} state_e;

  // A requested length of 0, or one larger than the vector, means the whole vector.
  function automatic int unsigned clamp_len(int unsigned len, int unsigned length);
    return (len == 0 || len > length) ? length : len;
  endfunction

endpackage

// File: rtl/sorted_list_streamer.sv
// Captures a sorted vector on sort_done and replays its first K elements as a
// valid/ready stream, tagging each beat with its index and a last flag.
module sorted_list_streamer
  import sorted_list_streamer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LENGTH = 8,
  localparam int unsigned LENGTH_WIDTH = $clog2(LENGTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [LENGTH-1:0][DATA_WIDTH-1:0]    data_sorted,
  input  logic                                 sort_done,
  input  logic [LENGTH_WIDTH:0]                stream_len,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic [LENGTH_WIDTH-1:0]              out_idx,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 overrun
);

  localparam int unsigned LimitWidth = LENGTH_WIDTH + 1;

  state_e                           state_q, state_d;
  logic [LENGTH-1:0][DATA_WIDTH-1:0] buf_q, buf_d;
  logic [LENGTH_WIDTH-1:0]          idx_q, idx_d;
  logic [LimitWidth-1:0]            limit_q, limit_d;
  logic                             overrun_q, overrun_d;
  logic                             is_last, xfer, capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      buf_q     <= '0;
      idx_q     <= '0;
      limit_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      idx_q     <= idx_d;
      limit_q   <= limit_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    is_last   = (state_q == StStream) && ({1'b0, idx_q} == limit_q - LimitWidth'(1));
    xfer      = (state_q == StStream) && out_ready;
    capture   = 1'b0;
    state_d   = state_q;
    buf_d     = buf_q;
    idx_d     = idx_q;
    limit_d   = limit_q;
    overrun_d = 1'b0;
    unique case (state_q)
      StIdle: capture = sort_done;
      StStream: begin
        if (xfer && is_last) begin
          // A new list arriving with the final beat is taken back-to-back.
          capture = sort_done;
          if (!sort_done) begin
            state_d = StIdle;
            idx_d   = '0;
          end
        end else begin
          if (xfer) idx_d = idx_q + LENGTH_WIDTH'(1);
          overrun_d = sort_done;
        end
      end
      default: state_d = StIdle;
    endcase
    if (capture) begin
      buf_d   = data_sorted;
      idx_d   = '0;
      limit_d = LimitWidth'(clamp_len(32'(stream_len), LENGTH));
      state_d = StStream;
    end
  end

  always_comb begin
    out_valid = (state_q == StStream);
    busy      = (state_q == StStream);
    out_last  = is_last;
    out_data  = buf_q[idx_q];
    out_idx   = idx_q;
    overrun   = overrun_q;
  end

endmodule

// File: doc/sorted_list_streamer.md
Name: sorted_list_streamer

Overview:
- Downstream companion to the list sorter.
- Captures the sorter's parallel sorted vector on its one-cycle done pulse and replays it as a serial valid/ready stream, one element per beat.
- The number of beats is programmable (top-K), and each beat carries its element index and a last flag.
- Decouples the sorter from a narrow, back-pressuring consumer such as a FIFO or AXI-Stream bridge.

Parameters:
- DATA_WIDTH, 32: width of one list element.
- LENGTH, 8: number of elements in the sorted vector; must be >= 2.
- LENGTH_WIDTH, $clog2(LENGTH) (localparam): index width.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_sorted  input  [LENGTH-1:0][DATA_WIDTH-1:0]  sorted vector from the sorter.
- sort_done  input  1  one-cycle pulse; data_sorted is valid in this cycle.
- stream_len  input  LENGTH_WIDTH+1  number of elements to emit. Sampled together with sort_done. 0 or any value > LENGTH means LENGTH.
- out_data  output  DATA_WIDTH  current element.
- out_idx  output  LENGTH_WIDTH  index of the current element within the sorted vector.
- out_valid  output  1  beat available.
- out_ready  input  1  consumer accepts the beat.
- out_last  output  1  high with the final beat of a list.
- busy  output  1  a list is captured and not fully drained.
- overrun  output  1  one-cycle pulse: sort_done arrived and was dropped.

Behaviour:
- Reset values: out_valid=0, out_last=0, busy=0, overrun=0, out_idx=0, out_data=0, capture buffer all zero, state=IDLE.
- Reset asserted mid-stream discards the list immediately. No partial beat completes.
- Storage: LENGTH x DATA_WIDTH register buffer, a limit register (LENGTH_WIDTH+1 bits), and an index register.
- out_data is a mux of the buffer by the index register. There is no combinational path from data_sorted or sort_done to any output.
- States: IDLE and STREAM.
- IDLE:
  - out_valid=0, busy=0.
  - On sort_done: buffer <= data_sorted, idx <= 0, limit <= clamped stream_len, go to STREAM.
  - Latency: sort_done in cycle N gives out_valid=1 in cycle N+1.
- STREAM:
  - out_valid=1, busy=1.
  - out_last = (idx == limit-1), compared at LENGTH_WIDTH+1 bits.
  - A transfer occurs when out_valid && out_ready. On transfer, idx <= idx+1.
  - On a transfer with out_last=1, go to IDLE, unless the simultaneous-event rule below applies.
- Handshake rules:
  - Once out_valid rises, out_data, out_idx and out_last stay stable until the transfer.
  - out_valid never drops without a transfer, except on reset.
  - With out_ready held at 1, one beat per cycle and no bubbles.
- Simultaneous events:
  - sort_done in the same cycle as the final transfer: capture the new list, idx <= 0, stay in STREAM. The next cycle presents element 0 of the new list with no bubble. overrun stays 0.
  - sort_done in STREAM at any other time: the vector is ignored, the buffer is unchanged, and overrun=1 in the next cycle only.
- Limit boundaries:
  - limit=1: a single beat with out_last=1 at idx 0.
  - limit=LENGTH: the last beat is at idx LENGTH-1. The index never wraps within a list.
- Order: elements are emitted in index order 0..limit-1, whatever sort order the sorter used.

Decomposition:
- Shared list package holds:
  - the element type: logic [DATA_WIDTH-1:0];
  - the vector type: [LENGTH-1:0] of the element type;
  - the state enum {IDLE, STREAM};
  - a clamp function that maps stream_len to the effective limit.
- The sorter and this block share the vector type.
- No sub-module. Buffer, index counter and FSM form one module of roughly 150 lines.

Test Plan:
1. LENGTH=8, data_sorted={7,6,5,4,3,2,1,0} (idx0=0), stream_len=0, out_ready=1, pulse sort_done: out_valid rises the next cycle, then 8 consecutive beats with out_data=0..7, out_idx=0..7, out_last only on idx 7. Then busy=0.
2. Same list with out_ready toggling 1,0,0,1,...: each beat is held stable while ready=0, the sequence 0..7 is complete with no duplicates, and out_valid never drops mid-list.
3. stream_len=3: exactly 3 beats (0,1,2) with out_last on idx 2. stream_len=9: clamped, so 8 beats. stream_len=1: 1 beat with out_last=1.
4. sort_done at beat idx 3 with different data: overrun pulses 1 cycle, the remaining beats 3..7 come from the original list, and the new data is never emitted.
5. Second sort_done coincident with the final transfer: the next cycle shows idx 0 of the new list, valid stays high, overrun=0.
6. Assert rst at beat idx 4 while out_ready=0: out_valid, busy and out_last go to 0 immediately and asynchronously. After release, the block is in IDLE and a new sort_done streams from idx 0.
